mac_tx_framer: RTL
==================

MAC_TX_FRAMER -- requirements
Module: mac_tx_framer

Interface
REQ-001 SHALL have parameter IFG_NIBBLES, default 24, giving idle nibble times between frames.
REQ-002 SHALL have parameter MIN_FRAME, default 60, giving the minimum payload byte count before FCS when padding.
REQ-003 SHALL have parameter PAD_EN, default 1; 1 enables zero-padding up to MIN_FRAME.
REQ-004 SHALL have port clk, input, 1 bit: MII transmit nibble clock; the only clock.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port tx_data, input, 8 bits: payload byte (DA through last payload byte, no preamble or FCS).
REQ-007 SHALL have port tx_valid, input, 1 bit: tx_data valid.
REQ-008 SHALL have port tx_last, input, 1 bit: qualifies tx_data as the final payload byte.
REQ-009 SHALL have port tx_ready, output, 1 bit: byte is accepted when tx_valid and tx_ready are both high.
REQ-010 SHALL have port phy_tx_en, output, 1 bit: MII TX_EN.
REQ-011 SHALL have port phy_txd, output, 4 bits: MII TXD.
REQ-012 SHALL have port phy_tx_err, output, 1 bit: MII TX_ER.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port underrun, output, 1 bit: one-cycle pulse on a mid-frame source underrun.

Function
REQ-015 SHALL implement states IDLE, PREAMBLE, SFD, DATA, PAD, FCS, ERR and IFG.
REQ-016 SHALL derive tx_ready from registered state only, with no combinational path from tx_valid.
REQ-017 SHALL drive tx_ready high in IDLE, and in DATA on the high-nibble cycle when the held byte is not marked last.
REQ-018 SHALL hold tx_ready low in all other states and cycles.
REQ-019 In IDLE with tx_valid high, SHALL capture tx_data and tx_last, and move to PREAMBLE on the next edge.
REQ-020 Latency: acceptance in cycle N; phy_tx_en first high in cycle N+1.
REQ-021 PREAMBLE SHALL drive phy_txd=0x5 for 15 cycles (N+1..N+15).
REQ-022 SFD SHALL drive phy_txd=0xD for one cycle (N+16).
REQ-023 DATA SHALL send each byte as bits[3:0], then bits[7:4] on the next cycle.
REQ-024 The first payload nibble SHALL appear at N+17.
REQ-025 SHALL keep a byte counter, 11 bits, saturating at 2047, incremented per byte sent, including pad bytes.
REQ-026 On the high-nibble cycle of a byte held with tx_last=1: if PAD_EN=1 and count<MIN_FRAME, next state SHALL be PAD; otherwise FCS.
REQ-027 PAD SHALL send 0x00 bytes (two 0x0 nibbles each) until count==MIN_FRAME, then go to FCS.
REQ-028 On the high-nibble cycle with tx_ready=1 and tx_valid=0, SHALL enter ERR.
REQ-029 ERR SHALL drive phy_tx_en=1, phy_tx_err=1, phy_txd=0x0 for one cycle and pulse underrun, then go to IFG with no FCS sent.
REQ-030 CRC-32 SHALL use reflected polynomial 0xEDB88320, init 0xFFFFFFFF, nibble-serial LSB-first, computed over payload and pad bytes.
REQ-031 The transmitted FCS SHALL be the bitwise inverse of the CRC register.
REQ-032 FCS SHALL send 8 nibbles, least-significant nibble first.
REQ-033 IFG SHALL hold phy_tx_en=0 for IFG_NIBBLES cycles, then return to IDLE; tx_valid SHALL be ignored during IFG.
REQ-034 phy_txd SHALL be 0x0 and phy_tx_err 0 whenever phy_tx_en is 0.
REQ-035 phy_tx_en, phy_txd and phy_tx_err SHALL be driven from registers.
REQ-036 Frames longer than 2047 bytes SHALL be transmitted intact; only the counter saturates.

Reset
REQ-037 On rst assertion, at any time including mid-frame, SHALL immediately force state=IDLE, phy_tx_en=0, phy_txd=0x0, phy_tx_err=0, underrun=0 and busy=0.
REQ-038 SHALL reset the byte counter to 0 and the CRC register to 0xFFFFFFFF.
REQ-039 While rst is high, tx_ready SHALL be 0; it SHALL go to 1 on the first cycle after rst deasserts.
REQ-040 A frame truncated by reset SHALL NOT resume after reset.

Verification
REQ-041 PAD_EN=0, payload ASCII "123456789" -> 16 preamble/SFD nibbles, 18 data nibbles, FCS nibbles 6,2,9,3,4,F,B,C, then 24 idle cycles.
REQ-042 PAD_EN=1, 14-byte payload -> 46 zero pad bytes; phy_tx_en high for exactly 144 consecutive cycles; FCS equal to the reference model.
REQ-043 Back-to-back 64-byte frames with tx_valid held high -> second preamble starts exactly IFG_NIBBLES+1 cycles after the first frame's last FCS nibble.
REQ-044 tx_valid dropped on the 10th byte request -> one nibble with phy_tx_err=1, underrun pulse of one cycle, no FCS, then IFG.
REQ-045 rst asserted during the FCS state -> phy_tx_en=0 in the same cycle; after release, a new frame starts with a full 15-nibble preamble.

Source files
------------

// File: rtl/mac_tx_framer.sv
// rtl/mac_tx_framer.sv - MII nibble transmit framer: preamble, SFD, payload, zero pad, CRC-32 FCS, IFG
module mac_tx_framer #(
  parameter int IFG_NIBBLES = 24,
  parameter int MIN_FRAME   = 60,
  parameter int PAD_EN      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       phy_tx_en,
  output logic [3:0] phy_txd,
  output logic       phy_tx_err,
  output logic       busy,
  output logic       underrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_SFD,
    S_DATA,
    S_PAD,
    S_FCS,
    S_ERR,
    S_IFG
  } state_t;

  localparam logic [31:0] CRC_POLY = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
  localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME);
  localparam logic [10:0] CNT_MAX  = 11'h7FF;
  // The IDLE cycle that accepts the next frame is the final idle nibble of
  // the gap, so the IFG state itself lasts one cycle less than IFG_NIBBLES.
  localparam int          IFG_CYC  = (IFG_NIBBLES > 1) ? IFG_NIBBLES - 1 : 1;
  localparam logic [15:0] IFG_LAST = 16'(IFG_CYC - 1);

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        hi, hi_nxt;
  logic [7:0]  byte_q, byte_nxt;
  logic        last_q, last_nxt;
  logic [10:0] byte_cnt, byte_cnt_nxt;
  logic [31:0] crc, crc_nxt;
  logic        armed;

  logic        en_nxt;
  logic [3:0]  txd_nxt;
  logic        err_nxt;
  logic        underrun_nxt;

  logic [3:0]  cur_nib;
  logic [31:0] crc_upd;
  logic [10:0] byte_cnt_inc;
  logic [2:0]  fcs_idx;

  // Reflected CRC-32 advanced by one nibble, bit 0 first.
  function automatic logic [31:0] crc_nibble(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ CRC_POLY;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // The nibble currently on the wire feeds the CRC in DATA; pad nibbles are zero.
  assign cur_nib      = (state == S_DATA) ? (hi ? byte_q[7:4] : byte_q[3:0]) : 4'h0;
  assign crc_upd      = crc_nibble(crc, cur_nib);
  assign byte_cnt_inc = (byte_cnt == CNT_MAX) ? byte_cnt : byte_cnt + 11'd1;
  assign fcs_idx      = cnt[2:0] + 3'd1;

  // Ready comes only from registered state; armed keeps it low until reset has been released.
  assign tx_ready = armed & ((state == S_IDLE) | ((state == S_DATA) & hi & ~last_q));
  assign busy     = (state != S_IDLE);

  // Next-state logic; phy outputs are computed here for the next cycle and registered.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    hi_nxt       = hi;
    byte_nxt     = byte_q;
    last_nxt     = last_q;
    byte_cnt_nxt = byte_cnt;
    crc_nxt      = crc;
    en_nxt       = 1'b0;
    txd_nxt      = 4'h0;
    err_nxt      = 1'b0;
    underrun_nxt = 1'b0;

    case (state)
      S_IDLE: begin
        if (tx_valid && tx_ready) begin
          byte_nxt     = tx_data;
          last_nxt     = tx_last;
          byte_cnt_nxt = '0;
          crc_nxt      = CRC_INIT;
          cnt_nxt      = '0;
          state_nxt    = S_PREAMBLE;
          en_nxt       = 1'b1;
          txd_nxt      = 4'h5;
        end
      end

      S_PREAMBLE: begin
        en_nxt = 1'b1;
        if (cnt == 16'd14) begin
          state_nxt = S_SFD;
          txd_nxt   = 4'hD;
        end else begin
          cnt_nxt = cnt + 16'd1;
          txd_nxt = 4'h5;
        end
      end

      S_SFD: begin
        state_nxt = S_DATA;
        hi_nxt    = 1'b0;
        en_nxt    = 1'b1;
        txd_nxt   = byte_q[3:0];
      end

      S_DATA: begin
        crc_nxt = crc_upd;
        en_nxt  = 1'b1;
        if (!hi) begin
          hi_nxt  = 1'b1;
          txd_nxt = byte_q[7:4];
        end else begin
          byte_cnt_nxt = byte_cnt_inc;
          if (last_q) begin
            if ((PAD_EN != 0) && (byte_cnt_inc < MIN_CNT)) begin
              state_nxt = S_PAD;
              hi_nxt    = 1'b0;
              txd_nxt   = 4'h0;
            end else begin
              state_nxt = S_FCS;
              cnt_nxt   = '0;
              txd_nxt   = ~crc_upd[3:0];
            end
          end else if (tx_valid) begin
            byte_nxt = tx_data;
            last_nxt = tx_last;
            hi_nxt   = 1'b0;
            txd_nxt  = tx_data[3:0];
          end else begin
            // Source starved mid-frame: signal the error instead of sending FCS.
            state_nxt    = S_ERR;
            err_nxt      = 1'b1;
            underrun_nxt = 1'b1;
          end
        end
      end

      S_PAD: begin
        crc_nxt = crc_upd;
        en_nxt  = 1'b1;
        if (!hi) begin
          hi_nxt = 1'b1;
        end else begin
          hi_nxt       = 1'b0;
          byte_cnt_nxt = byte_cnt_inc;
          if (byte_cnt_inc >= MIN_CNT) begin
            state_nxt = S_FCS;
            cnt_nxt   = '0;
            txd_nxt   = ~crc_upd[3:0];
          end
        end
      end

      S_FCS: begin
        if (cnt[2:0] == 3'd7) begin
          state_nxt = S_IFG;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
          en_nxt  = 1'b1;
          txd_nxt = ~crc[{fcs_idx, 2'b00} +: 4];
        end
      end

      S_ERR: begin
        state_nxt = S_IFG;
        cnt_nxt   = '0;
      end

      S_IFG: begin
        if (cnt >= IFG_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  // State, datapath and registered MII outputs; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      hi         <= 1'b0;
      byte_q     <= '0;
      last_q     <= 1'b0;
      byte_cnt   <= '0;
      crc        <= CRC_INIT;
      armed      <= 1'b0;
      phy_tx_en  <= 1'b0;
      phy_txd    <= 4'h0;
      phy_tx_err <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      hi         <= hi_nxt;
      byte_q     <= byte_nxt;
      last_q     <= last_nxt;
      byte_cnt   <= byte_cnt_nxt;
      crc        <= crc_nxt;
      armed      <= 1'b1;
      phy_tx_en  <= en_nxt;
      phy_txd    <= txd_nxt;
      phy_tx_err <= err_nxt;
      underrun   <= underrun_nxt;
    end
  end

endmodule
